data_read_capture_ctrl: RTL
===========================

DATA_READ_CAPTURE_CTRL -- requirements
Module: data_read_capture_ctrl

Interface
REQ-001 Parameter LAST_BUF, default 3: index (0..3) of the last buffer filled per capture.
REQ-002 S_AXI_ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 S_AXI_ARESETN  input  1  asynchronous, active-low reset.
REQ-004 cr_start  input  1  one-cycle start pulse from the CR write decode.
REQ-005 cr_abort  input  1  one-cycle abort pulse from the CR write decode.
REQ-006 sample_valid  input  1  sample_data is valid this cycle.
REQ-007 sample_data  input  32  incoming sample word.
REQ-008 buf_wr_en  output  1  buffer RAM write strobe.
REQ-009 buf_wr_sel  output  2  buffer select, 0..3.
REQ-010 buf_wr_addr  output  10  word address within the selected buffer.
REQ-011 buf_wr_data  output  32  word to write.
REQ-012 sr_c  output  1  capture-complete flag, drives SR.C.
REQ-013 busy  output  1  capture in progress.
REQ-014 capture_cnt  output  12  words written in the current or last capture.

Function
REQ-015 States: IDLE, ARM (only with the macro), CAPTURE, DONE; state register clocked by S_AXI_ACLK.
REQ-016 IDLE: cr_start -> CAPTURE (or ARM with the macro); clears sr_c and capture_cnt, and sets write pointer to sel=0, addr=0 on the same edge.
REQ-017 CAPTURE: each edge with sample_valid=1 registers buf_wr_en=1, buf_wr_data=sample_data, buf_wr_sel/addr=current pointer; the write strobe is visible one cycle after acceptance.
REQ-018 buf_wr_en is low in every cycle not following an accepted sample; there are no back-to-back gaps imposed, so one write per clock is sustained.
REQ-019 Pointer advance: addr+1; at addr=1023, addr wraps to 0 and sel+1.
REQ-020 The write at sel=LAST_BUF, addr=1023 is the last; on that edge state -> DONE; capture_cnt = (LAST_BUF+1)*1024 after it, saturating (4096 wraps to 0 in 12 bits, so capture_cnt is 13-bit internally and the output saturates at 4095).
REQ-021 DONE: sr_c=1 from the edge after entry, one cycle after the last buf_wr_en; state -> IDLE on the same edge.
REQ-022 sr_c stays 1 in IDLE until the next cr_start; samples are ignored in IDLE and DONE.
REQ-023 busy=1 in ARM and CAPTURE, else 0.
REQ-024 cr_start while busy is ignored.
REQ-025 cr_abort in ARM or CAPTURE: -> IDLE next edge, no further writes, sr_c stays 0, and capture_cnt holds.
REQ-026 cr_start and cr_abort in the same cycle: abort wins, and from IDLE nothing starts.
REQ-027 A sample accepted on the abort edge is discarded.

Reset
REQ-028 On S_AXI_ARESETN=0, asynchronously: state=IDLE, pointers=0, and buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, sr_c, busy, capture_cnt=0.
REQ-029 Reset mid-capture drops the capture, with no write strobe after reset assertion.
REQ-030 Operation resumes on the first edge after deassertion.

Configuration
REQ-031 Macro DATA_READ_TRIG_EN: when defined, an input trig_in (1 bit) and state ARM exist.
REQ-032 With DATA_READ_TRIG_EN, ARM waits for trig_in=1; on that edge -> CAPTURE, and samples are ignored before it. A sample with trig_in=1 and sample_valid=1 on that edge is the first word written.
REQ-033 Without DATA_READ_TRIG_EN: no trig_in port, no ARM state, and cr_start goes directly to CAPTURE.

Verification
REQ-034 LAST_BUF=0, cr_start, then 1024 continuous samples of value n: 1024 writes sel=0 at addr 0..1023 with data n, sr_c=1 one cycle after the last strobe, and capture_cnt=1024.
REQ-035 LAST_BUF=3, sample_valid toggling 50%: 4096 writes, sel 0->3 changing at addr wrap 1023->0, sr_c rises once, and capture_cnt=4095.
REQ-036 cr_abort after 100 samples: exactly 100 strobes, busy falls next edge, sr_c=0, and capture_cnt=100.
REQ-037 cr_start and cr_abort in the same cycle from IDLE: busy stays 0 and there are no writes; cr_start during CAPTURE: pointer unaffected.
REQ-038 Reset asserted after 500 samples: all outputs 0 immediately; a new cr_start then begins at sel=0, addr=0.
REQ-039 DATA_READ_TRIG_EN, cr_start, 10 samples, then trig_in=1 with sample 0xA5: the first write is 0xA5 at addr 0, and the 10 pre-trigger samples are not written.

Source files
------------

// File: rtl/data_read_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_read_capture_ctrl_if
// Description : Sample stream in and buffer-RAM write port out for the
//               data read capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_read_capture_ctrl_if;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        buf_wr_en;
    logic [1:0]  buf_wr_sel;
    logic [9:0]  buf_wr_addr;
    logic [31:0] buf_wr_data;

    // Capture controller side: consumes samples, drives the RAM write port
    modport master (
        input  sample_valid,
        input  sample_data,
        output buf_wr_en,
        output buf_wr_sel,
        output buf_wr_addr,
        output buf_wr_data
    );

    // Environment side: produces samples, receives the RAM writes
    modport slave (
        output sample_valid,
        output sample_data,
        input  buf_wr_en,
        input  buf_wr_sel,
        input  buf_wr_addr,
        input  buf_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/data_read_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_read_capture_ctrl
// Description : Captures a burst of sample words into up to four 1024-word
//               buffers, one write per accepted sample, then flags completion.
//               Optional macro DATA_READ_TRIG_EN adds a trig_in input and an
//               ARM state that holds off capture until the trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module data_read_capture_ctrl #(
    parameter int LAST_BUF = 3
) (
    input  wire logic         S_AXI_ACLK,
    input  wire logic         S_AXI_ARESETN,
    input  wire logic         cr_start,
    input  wire logic         cr_abort,
`ifdef DATA_READ_TRIG_EN
    input  wire logic         trig_in,
`endif
    data_read_capture_ctrl_if.master bus,
    output logic              sr_c,
    output logic              busy,
    output logic [11:0]       capture_cnt
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ARM     = 2'd1;
    localparam logic [1:0]  S_CAPTURE = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;

    // {sel, addr} of the final word of a capture
    localparam logic [11:0] c_LAST_PTR = 12'((LAST_BUF * 1024) + 1023);

    logic [1:0]  state_q, state_d;
    logic [11:0] ptr_q, ptr_d;
    logic [12:0] cnt_q, cnt_d;
    logic        sr_c_q, sr_c_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        w_trig;
    logic        w_start;
    logic        w_accept;
    logic        w_last;

`ifdef DATA_READ_TRIG_EN
    assign w_trig = trig_in;
`else
    assign w_trig = 1'b0;
`endif

    // Abort always wins over start, and starts are honoured only from IDLE
    assign w_start  = (state_q == S_IDLE) && cr_start && !cr_abort;
    // A sample is taken in CAPTURE, or on the trigger edge while armed
    assign w_accept = bus.sample_valid && !cr_abort &&
                      ((state_q == S_CAPTURE) || ((state_q == S_ARM) && w_trig));
    assign w_last   = (ptr_q == c_LAST_PTR);

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
`ifdef DATA_READ_TRIG_EN
                    state_d = S_ARM;
`else
                    state_d = S_CAPTURE;
`endif
                end
            end
            S_ARM: begin
                if (cr_abort)                 state_d = S_IDLE;
                else if (w_accept && w_last)  state_d = S_DONE;
                else if (w_trig)              state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (cr_abort)                 state_d = S_IDLE;
                else if (w_accept && w_last)  state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: write port, pointer, word count, completion flag
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sr_c_d    = sr_c_q;
        wr_en_d   = w_accept;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (w_start) begin
            ptr_d  = 12'd0;
            cnt_d  = 13'd0;
            sr_c_d = 1'b0;
        end else if (w_accept) begin
            wr_sel_d  = ptr_q[11:10];
            wr_addr_d = ptr_q[9:0];
            wr_data_d = bus.sample_data;
            // Address wrap at 1023 carries into the buffer select
            ptr_d     = ptr_q + 12'd1;
            cnt_d     = cnt_q + 13'd1;
        end
        if (state_q == S_DONE) sr_c_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ptr_q     <= 12'd0;
            cnt_q     <= 13'd0;
            sr_c_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 2'd0;
            wr_addr_q <= 10'd0;
            wr_data_q <= 32'd0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sr_c_q    <= sr_c_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_sel  = wr_sel_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.buf_wr_data = wr_data_q;
    assign sr_c            = sr_c_q;
    assign busy            = (state_q == S_CAPTURE) || (state_q == S_ARM);
    // A full four-buffer capture counts 4096, shown saturated at 4095
    assign capture_cnt     = cnt_q[12] ? 12'hFFF : cnt_q[11:0];

endmodule
`default_nettype wire
